// File: rtl/ema_burst_sequencer_if.sv
// ============================================================================
// Module      : ema_burst_sequencer_if
// Description : Request/config/drive bundle of the EMA excitation burst sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ema_burst_sequencer_if #(
    parameter int CHARGE_W = 24,
    parameter int WIDTH_W  = 8,
    parameter int GAP_W    = 8,
    parameter int PER_W    = 4,
    parameter int HOLD_W   = 16
);
    logic                start;
    logic                abort;
    logic [CHARGE_W-1:0] cfg_charge;
    logic [WIDTH_W-1:0]  cfg_width;
    logic [GAP_W-1:0]    cfg_gap;
    logic [PER_W-1:0]    cfg_periods;
    logic [HOLD_W-1:0]   cfg_hold;
    logic                busy;
    logic                done;
    logic                cfg_err;
    logic                ema_pulse_p;
    logic                ema_pulse_n;
    logic                on_32;
    logic                ctrl_sw;

    modport master (
        output start, abort, cfg_charge, cfg_width, cfg_gap, cfg_periods, cfg_hold,
        input  busy, done, cfg_err, ema_pulse_p, ema_pulse_n, on_32, ctrl_sw
    );

    modport slave (
        input  start, abort, cfg_charge, cfg_width, cfg_gap, cfg_periods, cfg_hold,
        output busy, done, cfg_err, ema_pulse_p, ema_pulse_n, on_32, ctrl_sw
    );
endinterface

`default_nettype wire

// File: rtl/ema_burst_sequencer.sv
// ============================================================================
// Module      : ema_burst_sequencer
// Description : Charge / alternating P-N pulse / hold burst sequencer, config latched at start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ema_burst_sequencer #(
    parameter int CHARGE_W = 24,
    parameter int WIDTH_W  = 8,
    parameter int GAP_W    = 8,
    parameter int PER_W    = 4,
    parameter int HOLD_W   = 16
) (
    input  wire logic            clk_80mhz,
    input  wire logic            rst_n,
    ema_burst_sequencer_if.slave bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHARGE  = 3'd1;
    localparam logic [2:0] S_PULSE_P = 3'd2;
    localparam logic [2:0] S_PULSE_N = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_HOLD    = 3'd5;

    logic [2:0]          r_state, w_next_state;
    logic [CHARGE_W-1:0] r_charge_cnt;
    logic [WIDTH_W-1:0]  r_width, r_width_cnt;
    logic [GAP_W-1:0]    r_gap, r_gap_cnt;
    logic [PER_W-1:0]    r_per_cnt;
    logic [HOLD_W-1:0]   r_hold, r_hold_cnt;

    logic r_busy, r_done, r_cfg_err, r_pulse_p, r_pulse_n, r_on_32, r_ctrl_sw;
    logic w_busy, w_done, w_cfg_err, w_pulse_p, w_pulse_n, w_on_32, w_ctrl_sw;
    logic w_cfg_ok, w_accept;

    assign w_cfg_ok = (bus.cfg_charge != '0) && (bus.cfg_width != '0) && (bus.cfg_periods != '0);
    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.abort && w_cfg_ok;

    // Every down-counter is loaded with (value-1) on entry and exits on zero.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next_state = S_CHARGE;
            S_CHARGE:  if (r_charge_cnt == '0) w_next_state = S_PULSE_P;
            S_PULSE_P: if (r_width_cnt == '0) w_next_state = S_PULSE_N;
            S_PULSE_N: begin
                if (r_width_cnt == '0) begin
                    if (r_per_cnt == '0)
                        w_next_state = (r_hold == '0) ? S_IDLE : S_HOLD;
                    else
                        w_next_state = (r_gap == '0) ? S_PULSE_P : S_GAP;
                end
            end
            S_GAP:     if (r_gap_cnt == '0) w_next_state = S_PULSE_P;
            S_HOLD:    if (r_hold_cnt == '0) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
        if ((r_state != S_IDLE) && bus.abort)
            w_next_state = S_IDLE;
    end

    // Outputs are decoded from the next state so the registered copies change on the transition edge.
    always_comb begin
        w_busy    = (w_next_state != S_IDLE);
        w_pulse_p = (w_next_state != S_PULSE_P);
        w_pulse_n = (w_next_state != S_PULSE_N);
        w_on_32   = (w_next_state == S_IDLE) || (w_next_state == S_HOLD);
        w_ctrl_sw = (w_next_state == S_PULSE_P) || (w_next_state == S_PULSE_N) ||
                    (w_next_state == S_GAP) || (w_next_state == S_HOLD) ||
                    ((w_next_state == S_CHARGE) &&
                     (((r_state == S_IDLE) && (bus.cfg_charge == CHARGE_W'(1))) ||
                      ((r_state == S_CHARGE) && (r_charge_cnt == CHARGE_W'(1)))));
        w_done    = (r_state != S_IDLE) && (w_next_state == S_IDLE) && !bus.abort;
        w_cfg_err = (r_state == S_IDLE) && bus.start && !bus.abort && !w_cfg_ok;
    end

    always_ff @(posedge clk_80mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_charge_cnt <= '0;
            r_width      <= '0;
            r_width_cnt  <= '0;
            r_gap        <= '0;
            r_gap_cnt    <= '0;
            r_per_cnt    <= '0;
            r_hold       <= '0;
            r_hold_cnt   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_pulse_p    <= 1'b1;
            r_pulse_n    <= 1'b1;
            r_on_32      <= 1'b1;
            r_ctrl_sw    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_cfg_err <= w_cfg_err;
            r_pulse_p <= w_pulse_p;
            r_pulse_n <= w_pulse_n;
            r_on_32   <= w_on_32;
            r_ctrl_sw <= w_ctrl_sw;

            if (w_accept) begin
                r_width      <= bus.cfg_width;
                r_gap        <= bus.cfg_gap;
                r_hold       <= bus.cfg_hold;
                r_charge_cnt <= bus.cfg_charge - CHARGE_W'(1);
                r_per_cnt    <= bus.cfg_periods - PER_W'(1);
            end else if ((r_state == S_CHARGE) && (r_charge_cnt != '0)) begin
                r_charge_cnt <= r_charge_cnt - CHARGE_W'(1);
            end

            if (((w_next_state == S_PULSE_P) || (w_next_state == S_PULSE_N)) &&
                (w_next_state != r_state))
                r_width_cnt <= r_width - WIDTH_W'(1);
            else if (r_width_cnt != '0)
                r_width_cnt <= r_width_cnt - WIDTH_W'(1);

            if ((w_next_state == S_GAP) && (r_state != S_GAP))
                r_gap_cnt <= r_gap - GAP_W'(1);
            else if (r_gap_cnt != '0)
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);

            if ((w_next_state == S_HOLD) && (r_state != S_HOLD))
                r_hold_cnt <= r_hold - HOLD_W'(1);
            else if (r_hold_cnt != '0)
                r_hold_cnt <= r_hold_cnt - HOLD_W'(1);

            if ((r_state == S_PULSE_N) && ((w_next_state == S_PULSE_P) || (w_next_state == S_GAP)))
                r_per_cnt <= r_per_cnt - PER_W'(1);
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.cfg_err     = r_cfg_err;
    assign bus.ema_pulse_p = r_pulse_p;
    assign bus.ema_pulse_n = r_pulse_n;
    assign bus.on_32       = r_on_32;
    assign bus.ctrl_sw     = r_ctrl_sw;

endmodule

`default_nettype wire

// File: tb/tb_ema_burst_sequencer.sv
// ============================================================================
// Module      : tb_ema_burst_sequencer
// Description : Directed self-checking bench for ema_burst_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ema_burst_sequencer;

    logic clk_80mhz = 1'b0;
    logic rst_n     = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    // Observed/expected vector layout: {busy, done, cfg_err, p, n, on_32, ctrl_sw}
    localparam logic [6:0] IDLE_V = 7'b0001110;
    localparam logic [6:0] ERR_V  = 7'b0011110;

    ema_burst_sequencer_if ifc ();

    ema_burst_sequencer dut (
        .clk_80mhz (clk_80mhz),
        .rst_n     (rst_n),
        .bus       (ifc.slave)
    );

    always #5 clk_80mhz = ~clk_80mhz;

    function automatic logic [6:0] obs();
        return {ifc.busy, ifc.done, ifc.cfg_err, ifc.ema_pulse_p, ifc.ema_pulse_n,
                ifc.on_32, ifc.ctrl_sw};
    endfunction

    // Expected outputs after edge E0+k from the burst timing formulas.
    function automatic logic [6:0] model(int k, int c, int w, int g, int p, int h);
        int   per  = 2 * w + g;
        int   eend = c + (p - 1) * per + 2 * w;
        int   fin  = eend + h;
        logic pl   = 1'b0;
        logic nl   = 1'b0;
        for (int i = 0; i < p; i++) begin
            if (k >= c + i * per && k < c + i * per + w)         pl = 1'b1;
            if (k >= c + i * per + w && k < c + i * per + 2 * w) nl = 1'b1;
        end
        return {(k >= 0 && k < fin), (k == fin), 1'b0, ~pl, ~nl,
                ~(k >= 0 && k < eend), (k >= c - 1 && k < fin)};
    endfunction

    task automatic tick();
        @(posedge clk_80mhz);
        #1;
    endtask

    task automatic set_cfg(int c, int w, int g, int p, int h);
        ifc.cfg_charge  = 24'(c);
        ifc.cfg_width   = 8'(w);
        ifc.cfg_gap     = 8'(g);
        ifc.cfg_periods = 4'(p);
        ifc.cfg_hold    = 16'(h);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_80mhz);
        #1;
        vectors++;
        if (obs() !== IDLE_V) begin
            miscompares++;
            $display("FAIL reset_held got %b want %b", obs(), IDLE_V);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (obs() !== IDLE_V) begin
            miscompares++;
            $display("FAIL reset_release got %b want %b", obs(), IDLE_V);
        end
    endtask

    task automatic test_nominal();
        logic [6:0] e;
        set_cfg(100, 10, 3, 2, 160);
        ifc.start = 1'b1;
        for (int k = 0; k <= 310; k++) begin
            tick();
            if (k == 0) ifc.start = 1'b0;
            if (k == 1) set_cfg(5, 2, 1, 1, 0);
            e = model(k, 100, 10, 3, 2, 160);
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL nominal k=%0d got %b want %b", k, obs(), e);
            end
        end
    endtask

    task automatic test_edge_cfg();
        logic [6:0] e;
        set_cfg(1, 1, 0, 3, 0);
        ifc.start = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            tick();
            if (k == 0) ifc.start = 1'b0;
            e = model(k, 1, 1, 0, 3, 0);
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL edge_cfg k=%0d got %b want %b", k, obs(), e);
            end
        end
    endtask

    task automatic test_reject();
        for (int t = 0; t < 3; t++) begin
            case (t)
                0:       set_cfg(100, 0, 3, 2, 160);
                1:       set_cfg(100, 10, 3, 0, 160);
                default: set_cfg(0, 10, 3, 2, 160);
            endcase
            ifc.start = 1'b1;
            tick();
            ifc.start = 1'b0;
            vectors++;
            if (obs() !== ERR_V) begin
                miscompares++;
                $display("FAIL reject_pulse case=%0d got %b want %b", t, obs(), ERR_V);
            end
            tick();
            vectors++;
            if (obs() !== IDLE_V) begin
                miscompares++;
                $display("FAIL reject_after case=%0d got %b want %b", t, obs(), IDLE_V);
            end
        end
    endtask

    task automatic test_abort();
        logic [6:0] e;
        set_cfg(100, 10, 3, 2, 160);
        ifc.start = 1'b1;
        for (int k = 0; k <= 130; k++) begin
            tick();
            if (k == 0) ifc.start = 1'b0;
            e = (k <= 115) ? model(k, 100, 10, 3, 2, 160) : IDLE_V;
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL abort k=%0d got %b want %b", k, obs(), e);
            end
            if (k == 115) ifc.abort = 1'b1;
            if (k == 116) ifc.abort = 1'b0;
        end
        test_nominal();
    endtask

    task automatic test_contention();
        logic [6:0] e;
        set_cfg(100, 10, 3, 2, 160);
        ifc.start = 1'b1;
        for (int k = 0; k <= 304 + 310; k++) begin
            tick();
            if (k == 0 || k == 50 || k == 304) ifc.start = 1'b0;
            if (k == 49 || k == 302) ifc.start = 1'b1;
            e = (k < 304) ? model(k, 100, 10, 3, 2, 160) : model(k - 304, 100, 10, 3, 2, 160);
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL contention k=%0d got %b want %b", k, obs(), e);
            end
        end
        ifc.start = 1'b1;
        ifc.abort = 1'b1;
        tick();
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs() !== IDLE_V) begin
                miscompares++;
                $display("FAIL start_abort_idle k=%0d got %b want %b", k, obs(), IDLE_V);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] e;
        set_cfg(100, 10, 3, 2, 160);
        ifc.start = 1'b1;
        for (int k = 0; k <= 105; k++) begin
            tick();
            if (k == 0) ifc.start = 1'b0;
            e = model(k, 100, 10, 3, 2, 160);
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL async_pre k=%0d got %b want %b", k, obs(), e);
            end
        end
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs() !== IDLE_V) begin
            miscompares++;
            $display("FAIL async_assert got %b want %b", obs(), IDLE_V);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if (obs() !== IDLE_V) begin
                miscompares++;
                $display("FAIL async_after k=%0d got %b want %b", k, obs(), IDLE_V);
            end
        end
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
        set_cfg(100, 10, 3, 2, 160);
        test_reset();
        test_nominal();
        test_edge_cfg();
        test_reject();
        test_abort();
        test_contention();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
